// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter: round-robin/burst popper of two VC FIFOs into one egress FIFO; VC_ARB_STRICT_PRIO_EN selects VC0 strict priority
module vc_pop_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int BURST = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] vc0_q,
  input  logic                  vc0_empty,
  input  logic [DATA_WIDTH-1:0] vc1_q,
  input  logic                  vc1_empty,
  input  logic                  out_full,
  input  logic                  out_almost_full,
  output logic                  vc0_pop,
  output logic                  vc1_pop,
  output logic                  push_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  last_vc,
  output logic                  error
);
  logic       both, en, gnt, pop_any;
  logic       rr_q, rr_d, pop_q, pop_d, sel_q, sel_d, last_q, last_d, err_q, err_d;
  logic [3:0] cnt_q, cnt_d;
  always_comb begin
    both    = ~vc0_empty & ~vc1_empty;
    en      = reset & ~out_almost_full & ~out_full;
`ifdef VC_ARB_STRICT_PRIO_EN
    gnt     = vc0_empty;
`else
    gnt     = both ? rr_q : ~vc1_empty;
`endif
    pop_any = en & ~(vc0_empty & vc1_empty);
    rr_d    = rr_q;
    cnt_d   = cnt_q;
`ifdef VC_ARB_STRICT_PRIO_EN
    rr_d    = 1'b0;
    cnt_d   = '0;
`else
    if (pop_any && (!both || cnt_q + 4'd1 == 4'(BURST))) begin
      rr_d  = ~gnt;
      cnt_d = '0;
    end else if (pop_any) cnt_d = cnt_q + 4'd1;
`endif
    pop_d   = pop_any;
    sel_d   = gnt;
    last_d  = pop_q ? sel_q : last_q;
    err_d   = err_q | (pop_q & out_full);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q   <= 1'b0;
      cnt_q  <= '0;
      pop_q  <= 1'b0;
      sel_q  <= 1'b0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      cnt_q  <= cnt_d;
      pop_q  <= pop_d;
      sel_q  <= sel_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end
  // The word on data_out is tagged with its VC in the same cycle; the tag holds while idle.
  assign vc0_pop  = pop_any & ~gnt;
  assign vc1_pop  = pop_any & gnt;
  assign push_out = pop_q;
  assign data_out = pop_q ? (sel_q ? vc1_q : vc0_q) : '0;
  assign last_vc  = pop_q ? sel_q : last_q;
  assign error    = err_q;
endmodule

// File: tb/tb_vc_pop_arbiter.sv
// tb_vc_pop_arbiter: directed bench; DUT a has BURST=1, DUT b has BURST=2, sharing one VC FIFO model
module tb_vc_pop_arbiter;
  logic clk = 0, reset = 0, af = 1, full = 0, sel = 0;
  logic [3:0] q0 = 0, q1 = 0, da, db, dm;
  logic p0a, p1a, pa, la, ea, p0b, p1b, pb, lb, eb;
  logic p0m, p1m, pm, lm, em;
  logic [3:0] mem0 [64], mem1 [64];
  int rd0 = 0, rd1 = 0, wr0 = 0, wr1 = 0;
  logic e0, e1;
  logic glog [64], vlog [64];
  logic [3:0] dlog [64];
  int g = 0, n = 0, cmp = 0, err = 0;
  always #5 clk = ~clk;
  assign e0 = rd0 == wr0;
  assign e1 = rd1 == wr1;
  vc_pop_arbiter #(.DATA_WIDTH(4), .BURST(1)) u_a (.clk(clk), .reset(reset), .vc0_q(q0), .vc0_empty(e0),
    .vc1_q(q1), .vc1_empty(e1), .out_full(full), .out_almost_full(af | sel), .vc0_pop(p0a), .vc1_pop(p1a),
    .push_out(pa), .data_out(da), .last_vc(la), .error(ea));
  vc_pop_arbiter #(.DATA_WIDTH(4), .BURST(2)) u_b (.clk(clk), .reset(reset), .vc0_q(q0), .vc0_empty(e0),
    .vc1_q(q1), .vc1_empty(e1), .out_full(full), .out_almost_full(af | ~sel), .vc0_pop(p0b), .vc1_pop(p1b),
    .push_out(pb), .data_out(db), .last_vc(lb), .error(eb));
  assign p0m = sel ? p0b : p0a;
  assign p1m = sel ? p1b : p1a;
  assign pm  = sel ? pb : pa;
  assign dm  = sel ? db : da;
  assign lm  = sel ? lb : la;
  assign em  = sel ? eb : ea;
  always @(posedge clk) begin
    if (p0m) begin q0 <= mem0[rd0]; rd0 <= rd0 + 1; end
    if (p1m) begin q1 <= mem1[rd1]; rd1 <= rd1 + 1; end
    if (p0m | p1m) begin glog[g] <= p1m; g <= g + 1; end
    if (pm) begin dlog[n] <= dm; vlog[n] <= lm; n <= n + 1; end
  end
  task automatic load(input logic vc, input logic [3:0] v);
    if (vc) begin mem1[wr1] = v; wr1 = wr1 + 1; end
    else begin mem0[wr0] = v; wr0 = wr0 + 1; end
  endtask
  task automatic do_reset();
    @(negedge clk) reset = 0;
    @(negedge clk) reset = 1;
  endtask
  task automatic drain();
    int t = 0;
    while (!(e0 && e1 && !pm) && t < 40) begin @(negedge clk); t++; end
    @(negedge clk);
    cmp++;
    if (t >= 40) begin err++; $display("FAIL drain_timeout: still busy after %0d cycles, required idle", t); end
    af = 1;
  endtask
  task automatic test_reset();
    load(0, 4'hE); load(1, 4'hD);
    reset = 0; af = 0;
    @(negedge clk); #1;
    cmp++;
    if ({p0a, p1a, pa, ea, la, da, p0b, p1b} !== 11'b0) begin
      err++; $display("FAIL reset_state: got %b required 0", {p0a, p1a, pa, ea, la, da, p0b, p1b});
    end
    af = 1; reset = 1;
    @(negedge clk);
    rd0 = wr0; rd1 = wr1;
  endtask
  task automatic test_single_vc();
    do_reset();
    load(0, 4'h1); load(0, 4'h2); load(0, 4'h3);
    @(negedge clk) af = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      cmp++;
      if ({p0a, p1a} !== {i < 3, 1'b0}) begin
        err++; $display("FAIL single_pop[%0d]: got %b%b required %b0", i, p0a, p1a, i < 3);
      end
      cmp++;
      if ({pa, da} !== ((i >= 1 && i <= 3) ? {1'b1, 4'(i)} : 5'b0)) begin
        err++; $display("FAIL single_push[%0d]: got push=%b data=%h required data %0d", i, pa, da, i);
      end
      cmp++;
      if (la !== 1'b0) begin err++; $display("FAIL single_last_vc[%0d]: got %b required 0", i, la); end
      @(negedge clk);
    end
    af = 1;
  endtask
  task automatic test_contention(input logic which);
    logic [7:0] exp;
    logic [3:0] w0, w1, ed;
    int g0, n0;
`ifdef VC_ARB_STRICT_PRIO_EN
    exp = 8'b11110000;
`else
    exp = which ? 8'b11001100 : 8'b10101010;
`endif
    sel = which;
    do_reset();
    for (int i = 0; i < 4; i++) begin load(0, 4'(4 + i)); load(1, 4'(8 + i)); end
    g0 = g; n0 = n;
    @(negedge clk) af = 0;
    drain();
    cmp++;
    if (n - n0 !== 8 || g - g0 !== 8) begin
      err++; $display("FAIL cont%0d_count: got pops=%0d pushes=%0d required 8/8", which, g - g0, n - n0);
    end
    w0 = 4; w1 = 8;
    for (int i = 0; i < 8; i++) begin
      ed = exp[i] ? w1 : w0;
      if (exp[i]) w1++; else w0++;
      cmp++;
      if (glog[g0 + i] !== exp[i] || vlog[n0 + i] !== exp[i] || dlog[n0 + i] !== ed) begin
        err++; $display("FAIL cont%0d_order[%0d]: got gnt=%b vc=%b data=%h required vc=%b data=%h",
          which, i, glog[g0 + i], vlog[n0 + i], dlog[n0 + i], exp[i], ed);
      end
    end
    sel = 0;
  endtask
  task automatic test_almost_full();
    do_reset();
    load(0, 4'h5); load(1, 4'h6);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      cmp++;
      if ({p0a, p1a, pa} !== 3'b0) begin
        err++; $display("FAIL af_hold[%0d]: got pop=%b%b push=%b required 000", i, p0a, p1a, pa);
      end
    end
    @(negedge clk) af = 0;
    #1;
    cmp++;
    if ({p0a, p1a} !== 2'b10) begin err++; $display("FAIL af_release_pop: got %b%b required 10", p0a, p1a); end
    @(negedge clk); #1;
    cmp++;
    if ({pa, da} !== 5'h15) begin err++; $display("FAIL af_release_push: got %b/%h required 1/5", pa, da); end
    drain();
  endtask
  task automatic test_reset_midstream();
    do_reset();
    load(0, 4'h7); load(0, 4'h8); load(1, 4'h9); load(1, 4'hA);
    @(negedge clk) af = 0;
    @(negedge clk); #1;
    cmp++;
    if (pa !== 1'b1) begin err++; $display("FAIL mid_inflight: got push=%b required 1", pa); end
    reset = 0;
    #1;
    cmp++;
    if ({pa, p0a, p1a} !== 3'b0) begin err++; $display("FAIL mid_reset_drop: got %b required 000", {pa, p0a, p1a}); end
    @(negedge clk) reset = 1;
    #1;
    cmp++;
    if ({p0a, p1a} !== 2'b10) begin err++; $display("FAIL mid_first_grant: got %b%b required 10", p0a, p1a); end
    drain();
  endtask
  task automatic test_error();
    do_reset();
    load(0, 4'hC);
    @(negedge clk) af = 0;
    @(negedge clk) full = 1;
    #1;
    cmp++;
    if ({pa, ea} !== 2'b10) begin err++; $display("FAIL err_pre: got push=%b error=%b required 1/0", pa, ea); end
    @(negedge clk) full = 0;
    #1;
    cmp++;
    if (ea !== 1'b1) begin err++; $display("FAIL err_set: got %b required 1", ea); end
    repeat (3) @(negedge clk);
    cmp++;
    if (ea !== 1'b1) begin err++; $display("FAIL err_sticky: got %b required 1", ea); end
    do_reset();
    cmp++;
    if (ea !== 1'b0) begin err++; $display("FAIL err_clear: got %b required 0", ea); end
    af = 1;
  endtask
  initial begin
    test_reset();
    test_single_vc();
    test_contention(0);
    test_contention(1);
    test_almost_full();
    test_reset_midstream();
    test_error();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
